// File: rtl/boot_fetch_if.sv
// boot_fetch_if: boot memory read port plus the outgoing word stream.
// master = fetch engine, slave = memory/consumer side.
interface boot_fetch_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output mem_rd, mem_addr, dout, dout_valid,
        input  mem_rdata, dout_ready
    );

    modport slave (
        input  mem_rd, mem_addr, dout, dout_valid,
        output mem_rdata, dout_ready
    );
endinterface

// File: rtl/boot_fetch.sv
// boot_fetch: reads a bitstream page range from boot memory and streams it
// out through a 2-entry buffer that hides the 1-cycle read latency.
module boot_fetch #(
    parameter int AW        = 16,
    parameter int PAGE_BITS = 8,
    parameter int DW        = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [7:0]   addr_i,
    input  logic [31:0]  len_i,
    boot_fetch_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int XW = AW + 33;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] base_q;
    logic [31:0]   len_q;
    logic [31:0]   issued_q;
    logic [31:0]   remaining_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          inflight_q;

    logic [DW-1:0] buf_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;

    logic [1:0]    count_d;
    logic [31:0]   remaining_d;
    logic [AW-1:0] start_base;
    logic [XW-1:0] req_end;
    logic          bad_req;
    logic          take;
    logic          push;
    logic          pop;
    logic          rd_en;
    logic [2:0]    pending;

    // Request check, buffer handshake and the read-issue rule.
    // A pop this cycle frees a slot, which keeps one word per cycle flowing.
    always_comb begin
        start_base  = AW'({addr_i, {PAGE_BITS{1'b0}}});
        req_end     = XW'(start_base) + XW'(len_i);
        bad_req     = (len_i == 32'd0) || (req_end > (XW'(1) << AW));
        take        = start && !busy_q;
        pop         = (count_q != 2'd0) && bus.dout_ready;
        push        = inflight_q;
        pending     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en       = (state_q == FETCH) && (issued_q < len_q)
                      && (pending < 3'd2);
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        remaining_d = remaining_q - 32'(pop);
    end

    assign bus.mem_rd     = rd_en;
    assign bus.mem_addr   = base_q + AW'(issued_q);
    assign bus.dout       = buf_q[rd_ptr_q];
    assign bus.dout_valid = (count_q != 2'd0);
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

    // Transfer sequencing: capture, issue, drain, completion pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q  <= rd_en;
            remaining_q <= remaining_d;
            done_q      <= 1'b0;
            if (rd_en) begin
                issued_q <= issued_q + 32'd1;
            end
            unique case (state_q)
                IDLE: state_q <= IDLE;
                FETCH: begin
                    if (issued_q == len_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_d == 2'd0 && remaining_d == 32'd0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                FIN: begin
                    // Error path arrives here with done still low and
                    // spends one cycle raising it.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
            if (take) begin
                base_q      <= start_base;
                len_q       <= len_i;
                remaining_q <= len_i;
                issued_q    <= '0;
                err_q       <= bad_req;
                busy_q      <= 1'b1;
                state_q     <= bad_req ? FIN : FETCH;
            end
        end
    end

    // Two-entry output buffer; clr also drops a read returning next cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_boot_fetch.sv
// tb_boot_fetch: directed transfers against a cycle-level model of the
// fetch engine's externally visible behaviour.
module tb_boot_fetch;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] data;
        int          avail;
    } ent_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  addr_i = 8'h0;
    logic [31:0] len_i = 32'h0;
    logic        busy;
    logic        done;
    logic        err;

    boot_fetch_if #(.AW(AW), .DW(DW)) bus ();

    boot_fetch #(.AW(AW), .PAGE_BITS(8), .DW(DW)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .addr_i (addr_i),
        .len_i  (len_i),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Boot memory: word k holds k, data one cycle after the strobe.
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_rd ? {16'h0, bus.mem_addr} : 32'hBAD0_0BAD;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state.
    ent_t        mq[$];
    int          to_issue = 0;
    logic [15:0] nxt = 16'h0;
    int          len_m = 0;
    int          acc_m = 0;
    int          done_at = -100;
    bit          m_busy = 0;
    bit          m_err = 0;

    // Logs for literal checks.
    logic [15:0] rd_log[$];
    logic [31:0] acc_log[$];
    int          done_cyc = -1;

    always @(negedge clk) begin
        bit          ev;
        bit          pp;
        bit          er;
        bit          tk;
        bit          bq;
        int          n;
        longint      base;
        ev = (mq.size() > 0) && (mq[0].avail <= cyc);
        pp = ev && (bus.dout_ready == 1'b1);
        n  = mq.size() - (pp ? 1 : 0);
        er = (to_issue > 0) && (n < 2);
        tk = (start == 1'b1) && !m_busy;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, cyc == done_at);
            chk("err", err, m_err);
            chk("mem_rd", bus.mem_rd, er);
            if (er) chk("mem_addr", bus.mem_addr, nxt);
            chk("dout_valid", bus.dout_valid, ev);
            if (ev) chk("dout", bus.dout, mq[0].data);
        end
        if (done === 1'b1) done_cyc = cyc;
        if (bus.mem_rd === 1'b1) rd_log.push_back(bus.mem_addr);
        if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1)
            acc_log.push_back(bus.dout);
        if (pp) begin
            void'(mq.pop_front());
            acc_m++;
            if (acc_m == len_m) done_at = cyc + 1;
        end
        if (er) begin
            mq.push_back('{data: 32'(nxt), avail: cyc + 2});
            nxt++;
            to_issue--;
        end
        if (done_at == cyc + 1) m_busy = 0;
        if (tk) begin
            base     = longint'(addr_i) * 256;
            bq       = (len_i == 0) || (base + longint'(len_i) > 65536);
            m_busy   = 1;
            m_err    = bq;
            len_m    = int'(len_i);
            acc_m    = 0;
            nxt      = 16'(base);
            to_issue = bq ? 0 : int'(len_i);
            done_at  = bq ? cyc + 2 : -100;
        end
        if (clr) begin
            mq.delete();
            m_busy   = 0;
            m_err    = 0;
            to_issue = 0;
            done_at  = -100;
            acc_m    = 0;
            len_m    = 0;
        end
    end

    bit rmode = 0;
    int pk = 0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int sc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        bus.dout_ready = rmode ? pat[pk % 6] : 1'b1;
        pk++;
    endtask

    task automatic go(input logic [7:0] a, input logic [31:0] l);
        rd_log.delete();
        acc_log.delete();
        done_cyc = -1;
        addr_i = a;
        len_i = l;
        start = 1'b1;
        sc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (done_cyc < sc && k < maxc) begin
            step();
            k++;
        end
        if (done_cyc < sc) begin
            total++;
            bad++;
            $display("FAIL done timeout: got none want pulse within %0d", maxc);
        end
    endtask

    initial begin
        bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst mem_rd", bus.mem_rd, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst dout", bus.dout, 0);
        chk("rst dout_valid", bus.dout_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        step();

        // Basic transfer.
        go(8'h03, 32'd4);
        wait_done(50);
        chk("basic latency", done_cyc - sc, 7);
        chk("basic nrd", rd_log.size(), 4);
        chk("basic nacc", acc_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic addr", rd_log[i], 16'h0300 + 16'(i));
            chk("basic word", acc_log[i], 32'h300 + 32'(i));
        end
        chk("basic err", err, 0);

        // Backpressure.
        rmode = 1;
        pk = 0;
        go(8'h05, 32'd6);
        wait_done(100);
        rmode = 0;
        chk("bp nacc", acc_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("bp word", acc_log[i], 32'h500 + 32'(i));

        // Zero length, then a valid start clears err.
        go(8'h10, 32'd0);
        wait_done(10);
        chk("zero latency", done_cyc - sc, 2);
        chk("zero nrd", rd_log.size(), 0);
        chk("zero err", err, 1);
        go(8'h01, 32'd1);
        chk("err cleared", err, 0);
        wait_done(20);
        chk("one latency", done_cyc - sc, 4);
        chk("one word", acc_log[0], 32'h100);

        // Overflow and the exact-fit boundary.
        go(8'hFF, 32'd300);
        wait_done(10);
        chk("ovf err", err, 1);
        chk("ovf nrd", rd_log.size(), 0);
        chk("ovf latency", done_cyc - sc, 2);
        go(8'hFF, 32'd256);
        wait_done(400);
        chk("fit err", err, 0);
        chk("fit nrd", rd_log.size(), 256);
        chk("fit last addr", rd_log[255], 16'hFFFF);
        chk("fit latency", done_cyc - sc, 259);
        go(8'hFF, 32'd257);
        wait_done(10);
        chk("fit+1 err", err, 1);

        // Start while busy is ignored.
        go(8'h02, 32'd8);
        repeat (3) step();
        addr_i = 8'h07;
        len_i = 32'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(50);
        chk("ign nacc", acc_log.size(), 8);
        chk("ign last", acc_log[7], 32'h207);
        chk("ign latency", done_cyc - sc, 11);
        chk("ign err", err, 0);

        // Reset in the middle of a long transfer.
        begin
            int k = 0;
            go(8'h01, 32'd400);
            while (acc_log.size() < 10 && k < 100) begin
                step();
                k++;
            end
            chk("mid reached 10", acc_log.size() >= 10, 1);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr busy", busy, 0);
        chk("clr dout_valid", bus.dout_valid, 0);
        chk("clr mem_rd", bus.mem_rd, 0);
        step();
        go(8'h03, 32'd2);
        wait_done(20);
        chk("post nacc", acc_log.size(), 2);
        chk("post w0", acc_log[0], 32'h300);
        chk("post w1", acc_log[1], 32'h301);
        chk("post err", err, 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
